// File: rtl/cnn_layer_sequencer.sv
// Sequences a CONV -> POOL -> FC engine pipeline with per-layer cycle counters
// and a per-layer watchdog that parks the sequencer in ERR on timeout.
module cnn_layer_sequencer #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   conv_start,
    output logic                   pool_start,
    output logic                   fc_start,
    input  logic                   conv_done,
    input  logic                   pool_done,
    input  logic                   fc_done,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [CNT_WIDTH-1:0]   conv_cycles,
    output logic [CNT_WIDTH-1:0]   pool_cycles,
    output logic [CNT_WIDTH-1:0]   fc_cycles,
    output logic [CNT_WIDTH+1:0]   total_cycles,
    output logic [2:0]             current_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CONV = 3'd1,
        S_POOL = 3'd2,
        S_FC   = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] conv_cnt_q, conv_cnt_d;
    logic [CNT_WIDTH-1:0] pool_cnt_q, pool_cnt_d;
    logic [CNT_WIDTH-1:0] fc_cnt_q, fc_cnt_d;
    logic                 conv_start_q, conv_start_d;
    logic                 pool_start_q, pool_start_d;
    logic                 fc_start_q, fc_start_d;
    logic                 error_q, error_d;
    logic                 launch;

    always_comb begin
        state_d      = state_q;
        conv_cnt_d   = conv_cnt_q;
        pool_cnt_d   = pool_cnt_q;
        fc_cnt_d     = fc_cnt_q;
        error_d      = error_q;
        conv_start_d = 1'b0;
        pool_start_d = 1'b0;
        fc_start_d   = 1'b0;
        launch       = 1'b0;

        // The watchdog compares the count including the current cycle, so a
        // layer gets exactly TIMEOUT cycles and completion on the last one wins.
        case (state_q)
            S_IDLE, S_ERR: launch = start;
            S_DONE: begin
                state_d = S_IDLE;
                launch  = start;
            end
            S_CONV: begin
                conv_cnt_d = conv_cnt_q + CNT_ONE;
                if (conv_done) begin
                    state_d      = S_POOL;
                    pool_start_d = 1'b1;
                end else if (conv_cnt_d == CNT_LIMIT) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end
            end
            S_POOL: begin
                pool_cnt_d = pool_cnt_q + CNT_ONE;
                if (pool_done) begin
                    state_d    = S_FC;
                    fc_start_d = 1'b1;
                end else if (pool_cnt_d == CNT_LIMIT) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end
            end
            S_FC: begin
                fc_cnt_d = fc_cnt_q + CNT_ONE;
                if (fc_done) begin
                    state_d = S_DONE;
                end else if (fc_cnt_d == CNT_LIMIT) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            state_d      = S_CONV;
            conv_start_d = 1'b1;
            conv_cnt_d   = '0;
            pool_cnt_d   = '0;
            fc_cnt_d     = '0;
            error_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            conv_cnt_q   <= '0;
            pool_cnt_q   <= '0;
            fc_cnt_q     <= '0;
            conv_start_q <= 1'b0;
            pool_start_q <= 1'b0;
            fc_start_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            conv_cnt_q   <= conv_cnt_d;
            pool_cnt_q   <= pool_cnt_d;
            fc_cnt_q     <= fc_cnt_d;
            conv_start_q <= conv_start_d;
            pool_start_q <= pool_start_d;
            fc_start_q   <= fc_start_d;
            error_q      <= error_d;
        end
    end

    assign conv_start    = conv_start_q;
    assign pool_start    = pool_start_q;
    assign fc_start      = fc_start_q;
    assign busy          = (state_q == S_CONV) || (state_q == S_POOL) || (state_q == S_FC);
    assign done          = (state_q == S_DONE);
    assign error         = error_q;
    assign conv_cycles   = conv_cnt_q;
    assign pool_cycles   = pool_cnt_q;
    assign fc_cycles     = fc_cnt_q;
    assign total_cycles  = (CNT_WIDTH+2)'(conv_cnt_q) + (CNT_WIDTH+2)'(pool_cnt_q)
                         + (CNT_WIDTH+2)'(fc_cnt_q);
    assign current_state = state_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: two instances (long and short watchdog) share
// stimulus and are checked every cycle against a per-run behavioural model.
module tb_cnn_layer_sequencer;

    logic clk = 1'b0;
    logic reset, start, conv_done, pool_done, fc_done;

    logic        cst [2];
    logic        pst [2];
    logic        fst [2];
    logic        bsy [2];
    logic        dn  [2];
    logic        err [2];
    logic [15:0] cc  [2];
    logic [15:0] pc  [2];
    logic [15:0] fcc [2];
    logic [17:0] tot [2];
    logic [2:0]  cs  [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int rel;

    always #5 clk = ~clk;

    cnn_layer_sequencer #(.CNT_WIDTH(16), .TIMEOUT(50000)) dut_long (
        .clk(clk), .reset(reset), .start(start),
        .conv_start(cst[0]), .pool_start(pst[0]), .fc_start(fst[0]),
        .conv_done(conv_done), .pool_done(pool_done), .fc_done(fc_done),
        .busy(bsy[0]), .done(dn[0]), .error(err[0]),
        .conv_cycles(cc[0]), .pool_cycles(pc[0]), .fc_cycles(fcc[0]),
        .total_cycles(tot[0]), .current_state(cs[0])
    );

    cnn_layer_sequencer #(.CNT_WIDTH(16), .TIMEOUT(8)) dut_short (
        .clk(clk), .reset(reset), .start(start),
        .conv_start(cst[1]), .pool_start(pst[1]), .fc_start(fst[1]),
        .conv_done(conv_done), .pool_done(pool_done), .fc_done(fc_done),
        .busy(bsy[1]), .done(dn[1]), .error(err[1]),
        .conv_cycles(cc[1]), .pool_cycles(pc[1]), .fc_cycles(fcc[1]),
        .total_cycles(tot[1]), .current_state(cs[1])
    );

    // Model: phase 0 idle, 1..3 = layer index+1, 4 done, 5 error.
    int m_to    [2] = '{50000, 8};
    int m_phase [2] = '{0, 0};
    int m_cnt   [2][3];
    bit m_err   [2];
    bit m_pulse [2][3];

    task automatic model_step(input int i);
        bit go;
        int layer;
        bit fin [3];
        go = 1'b0;
        fin[0] = conv_done;
        fin[1] = pool_done;
        fin[2] = fc_done;
        for (int k = 0; k < 3; k++) m_pulse[i][k] = 1'b0;
        if (reset) begin
            m_phase[i] = 0;
            m_err[i]   = 1'b0;
            for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
        end else if (m_phase[i] == 0 || m_phase[i] == 5) begin
            go = start;
        end else if (m_phase[i] == 4) begin
            m_phase[i] = 0;
            go = start;
        end else begin
            layer = m_phase[i] - 1;
            m_cnt[i][layer] = m_cnt[i][layer] + 1;
            if (fin[layer]) begin
                m_phase[i] = m_phase[i] + 1;
                if (layer < 2) m_pulse[i][layer+1] = 1'b1;
            end else if (m_cnt[i][layer] == m_to[i]) begin
                m_phase[i] = 5;
                m_err[i]   = 1'b1;
            end
        end
        if (go) begin
            m_phase[i] = 1;
            m_err[i]   = 1'b0;
            for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
            m_pulse[i][0] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d current_state", i), 64'(cs[i]), 64'(m_phase[i]));
                chk($sformatf("u%0d busy", i), 64'(bsy[i]), 64'(m_phase[i] >= 1 && m_phase[i] <= 3));
                chk($sformatf("u%0d done", i), 64'(dn[i]), 64'(m_phase[i] == 4));
                chk($sformatf("u%0d error", i), 64'(err[i]), 64'(m_err[i]));
                chk($sformatf("u%0d conv_start", i), 64'(cst[i]), 64'(m_pulse[i][0]));
                chk($sformatf("u%0d pool_start", i), 64'(pst[i]), 64'(m_pulse[i][1]));
                chk($sformatf("u%0d fc_start", i), 64'(fst[i]), 64'(m_pulse[i][2]));
                chk($sformatf("u%0d conv_cycles", i), 64'(cc[i]), 64'(m_cnt[i][0]));
                chk($sformatf("u%0d pool_cycles", i), 64'(pc[i]), 64'(m_cnt[i][1]));
                chk($sformatf("u%0d fc_cycles", i), 64'(fcc[i]), 64'(m_cnt[i][2]));
                chk($sformatf("u%0d total_cycles", i), 64'(tot[i]),
                    64'(m_cnt[i][0] + m_cnt[i][1] + m_cnt[i][2]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        rel++;
    endtask

    task automatic go_to(input int k);
        while (rel < k) tick();
    endtask

    task automatic begin_run();
        start = 1'b1;
        rel = 0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        conv_done = 1'b0; pool_done = 1'b0; fc_done = 1'b0;
        rel = 0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset state", 64'(cs[0]), 0);
        chk("reset counters", 64'(tot[0]), 0);
        chk("reset busy/done/error", 64'({bsy[1], dn[1], err[1]}), 0);
        reset = 1'b0;
        tick();

        // Nominal run: conv done at t+10, pool at t+15, fc at t+40.
        begin_run();
        chk("nominal conv_start t+1", 64'(cst[0]), 1);
        go_to(10); conv_done = 1'b1;
        go_to(11); conv_done = 1'b0;
        go_to(15); pool_done = 1'b1;
        go_to(16); pool_done = 1'b0;
        go_to(40); fc_done = 1'b1;
        go_to(41); fc_done = 1'b0;
        chk("nominal done t+41", 64'(dn[0]), 1);
        chk("nominal conv_cycles", 64'(cc[0]), 10);
        chk("nominal pool_cycles", 64'(pc[0]), 5);
        chk("nominal fc_cycles", 64'(fcc[0]), 25);
        chk("nominal total_cycles", 64'(tot[0]), 40);
        chk("nominal error", 64'(err[0]), 0);
        chk("short conv timeout state", 64'(cs[1]), 5);
        chk("short conv timeout count", 64'(cc[1]), 8);
        go_to(42);

        // Zero-wait engines.
        conv_done = 1'b1; pool_done = 1'b1; fc_done = 1'b1;
        begin_run();
        chk("zero-wait conv_start t+1", 64'(cst[0]), 1);
        tick();
        chk("zero-wait pool_start t+2", 64'(pst[0]), 1);
        tick();
        chk("zero-wait fc_start t+3", 64'(fst[1]), 1);
        tick();
        chk("zero-wait done t+4", 64'({dn[0], dn[1]}), 2'b11);
        chk("zero-wait total", 64'(tot[1]), 3);
        conv_done = 1'b0; pool_done = 1'b0; fc_done = 1'b0;
        tick();

        // Pool timeout on the short watchdog; long instance completes later.
        begin_run();
        go_to(3); conv_done = 1'b1;
        go_to(4); conv_done = 1'b0;
        go_to(12);
        chk("timeout state ERR", 64'(cs[1]), 5);
        chk("timeout error", 64'(err[1]), 1);
        chk("timeout pool_cycles", 64'(pc[1]), 8);
        chk("timeout conv_cycles", 64'(cc[1]), 3);
        go_to(20); pool_done = 1'b1;
        go_to(21); pool_done = 1'b0; fc_done = 1'b1;
        go_to(22); fc_done = 1'b0;
        chk("long done after slow pool", 64'(dn[0]), 1);
        chk("short no done in ERR", 64'(dn[1]), 0);
        chk("short pool_cycles held", 64'(pc[1]), 8);
        start = 1'b1;
        go_to(23); start = 1'b0;
        chk("restart clears error", 64'(err[1]), 0);
        chk("restart clears pool_cycles", 64'(pc[1]), 0);
        chk("back-to-back from DONE", 64'(cs[0]), 1);

        // Boundary: conv_done exactly on count 8 with TIMEOUT=8.
        go_to(30); conv_done = 1'b1;
        go_to(31); conv_done = 1'b0;
        chk("boundary enters POOL", 64'(cs[1]), 2);
        chk("boundary no error", 64'(err[1]), 0);
        chk("boundary conv_cycles", 64'(cc[1]), 8);

        // Reset in the third POOL cycle, with start and done inputs high.
        go_to(33);
        reset = 1'b1; start = 1'b1;
        conv_done = 1'b1; pool_done = 1'b1; fc_done = 1'b1;
        go_to(34);
        reset = 1'b0; start = 1'b0;
        chk("mid-pool reset state", 64'(cs[0]), 0);
        chk("mid-pool reset pool_cycles", 64'(pc[0]), 0);
        chk("mid-pool reset pool_start", 64'(pst[0]), 0);
        go_to(35);
        chk("stale done ignored in IDLE", 64'(cs[1]), 0);
        conv_done = 1'b0; pool_done = 1'b0; fc_done = 1'b0;
        tick();

        // Start held high all run, stray fc_done during CONV.
        start = 1'b1;
        rel = 0;
        go_to(2); fc_done = 1'b1;
        go_to(3); fc_done = 1'b0;
        go_to(5); conv_done = 1'b1;
        go_to(6); conv_done = 1'b0;
        go_to(7); pool_done = 1'b1;
        go_to(8); pool_done = 1'b0;
        go_to(9); fc_done = 1'b1;
        go_to(10); fc_done = 1'b0;
        chk("held-start done", 64'({dn[0], dn[1]}), 2'b11);
        chk("held-start conv_cycles", 64'(cc[0]), 5);
        chk("held-start fc_cycles", 64'(fcc[1]), 2);
        go_to(11);
        start = 1'b0;
        chk("held-start back-to-back conv_start", 64'(cst[0]), 1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            tick();
            start     = ($urandom_range(0, 7) == 0);
            conv_done = ($urandom_range(0, 4) == 0);
            pool_done = ($urandom_range(0, 4) == 0);
            fc_done   = ($urandom_range(0, 4) == 0);
            reset     = ($urandom_range(0, 149) == 0);
        end
        tick();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
